// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank clock-enable generator.
package clk_div_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   // Ratios at or below this value bypass the divider (enable every cycle).
   localparam int DIV_BYPASS_MAX = 1;

   // Channel-select width; a single channel still needs a one-bit select.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active ratio, shadow ratio and pending flag.
// Updates written while running wait in the shadow until the period boundary.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             leave,
   input  logic             wr,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             en,
   output logic             div_clk,
   output logic             ch_locked,
   output logic             pending
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] shadow;
   logic             pending_q;
   logic             bypass;
   logic             at_wrap;

   // Period decode taken straight from the registered counter and ratio.
   always_comb begin
      bypass    = (div <= DIV_W'(DIV_BYPASS_MAX));
      at_wrap   = (cnt == (div - DIV_W'(1)));
      en        = run & (bypass | at_wrap);
      div_clk   = run & ~bypass & (cnt < (div >> 1));
      ch_locked = run & ~pending_q;
      pending   = pending_q;
   end

   // Counter and ratio registers; a pending ratio lands only on a wrap, in bypass, or when leaving RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         div       <= DIV_W'(DEF_DIV);
         shadow    <= DIV_W'(DEF_DIV);
         pending_q <= 1'b0;
      end else if (!run || leave) begin
         cnt       <= '0;
         pending_q <= 1'b0;
         if (wr) begin
            div <= cfg_div;
         end else if (pending_q) begin
            div <= shadow;
         end
      end else if (pending_q && (bypass || at_wrap)) begin
         div       <= shadow;
         pending_q <= 1'b0;
         cnt       <= '0;
      end else begin
         if (wr) begin
            shadow    <= cfg_div;
            pending_q <= 1'b1;
         end
         if (bypass || at_wrap) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable clock-enable dividers released after a stable PLL lock.
// Optional feature macro: CLK_DIV_BANK_LOSS_CNT_EN adds loss_cnt_o, a saturating
// count of lock losses while running.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   parameter  int DIV_W     = 8,
   parameter  int LOCK_WAIT = 16,
   parameter  int DEF_DIV   = 2,
   localparam int CH_W      = ch_width(NUM_CH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              pll_locked_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   output logic [NUM_CH-1:0] en_o,
   output logic [NUM_CH-1:0] div_clk_o,
   output logic [NUM_CH-1:0] ch_locked_o,
   output logic              locked_o,
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
   output logic [7:0]        loss_cnt_o,
`endif
   output logic              rst_no
);

   localparam int LW_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   state_t            state;
   state_t            state_next;
   logic [LW_W-1:0]   lock_cnt;
   logic [LW_W-1:0]   lock_cnt_next;
   logic              locked_q;
   logic              run;
   logic              leave;
   logic              accept;
   logic [NUM_CH-1:0] wr;
   logic [NUM_CH-1:0] pending;

   // State, lock counter and the registered lock/reset outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= WAIT_LOCK;
         lock_cnt <= '0;
         locked_q <= 1'b0;
      end else begin
         state    <= state_next;
         lock_cnt <= lock_cnt_next;
         locked_q <= (state_next == RUN);
      end
   end

   // Lock qualification: require LOCK_WAIT consecutive locked cycles before RUN.
   always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      case (state)
         WAIT_LOCK: begin
            if (pll_locked_i) begin
               state_next    = SETTLE;
               lock_cnt_next = '0;
            end
         end
         SETTLE: begin
            if (!pll_locked_i) begin
               state_next = WAIT_LOCK;
            end else if (lock_cnt == LW_W'(LOCK_WAIT - 1)) begin
               state_next = RUN;
            end else begin
               lock_cnt_next = lock_cnt + LW_W'(1);
            end
         end
         RUN: begin
            if (!pll_locked_i) begin
               state_next = WAIT_LOCK;
            end
         end
         default: begin
            state_next = WAIT_LOCK;
         end
      endcase
   end

   // Handshake decode; out-of-range channel numbers are accepted but match no channel.
   always_comb begin
      run         = (state == RUN);
      leave       = run & ~pll_locked_i;
      cfg_ready_o = ~|pending;
      accept      = cfg_valid_i & cfg_ready_o;
      locked_o    = locked_q;
      rst_no      = locked_q;
      for (int i = 0; i < NUM_CH; i++) begin
         wr[i] = accept && (cfg_ch_i == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk       (clk_i),
         .rst_n     (rst_ni),
         .run       (run),
         .leave     (leave),
         .wr        (wr[g]),
         .cfg_div   (cfg_div_i),
         .en        (en_o[g]),
         .div_clk   (div_clk_o[g]),
         .ch_locked (ch_locked_o[g]),
         .pending   (pending[g])
      );
   end

`ifdef CLK_DIV_BANK_LOSS_CNT_EN
   logic [7:0] loss_cnt;

   // Count RUN exits caused by lock loss, saturating at 255.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         loss_cnt <= 8'd0;
      end else if (leave && (loss_cnt != 8'hFF)) begin
         loss_cnt <= loss_cnt + 8'd1;
      end
   end

   assign loss_cnt_o = loss_cnt;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed testbench for clk_div_bank. Main instance: 4 channels, LOCK_WAIT=16,
// DEF_DIV=2. Second instance: 3 channels so an out-of-range select is expressible.
module tb_clk_div_bank;

   logic       clk;
   logic       rst_n;
   logic       pll;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [3:0] en;
   logic [3:0] div_clk;
   logic [3:0] ch_locked;
   logic       locked;
   logic       rst_out;

   logic       pll_b;
   logic       cfg_valid_b;
   logic       cfg_ready_b;
   logic [1:0] cfg_ch_b;
   logic [7:0] cfg_div_b;
   logic [2:0] en_b;
   logic [2:0] div_clk_b;
   logic [2:0] ch_locked_b;
   logic       locked_b;
   logic       rst_out_b;

`ifdef CLK_DIV_BANK_LOSS_CNT_EN
   logic [7:0] loss_cnt;
   logic [7:0] loss_cnt_b;
`endif

   int vectors     = 0;
   int miscompares = 0;

   clk_div_bank #(
      .NUM_CH    (4),
      .DIV_W     (8),
      .LOCK_WAIT (16),
      .DEF_DIV   (2)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .pll_locked_i (pll),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .cfg_ch_i     (cfg_ch),
      .cfg_div_i    (cfg_div),
      .en_o         (en),
      .div_clk_o    (div_clk),
      .ch_locked_o  (ch_locked),
      .locked_o     (locked),
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
      .loss_cnt_o   (loss_cnt),
`endif
      .rst_no       (rst_out)
   );

   clk_div_bank #(
      .NUM_CH    (3),
      .DIV_W     (8),
      .LOCK_WAIT (1),
      .DEF_DIV   (3)
   ) dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .pll_locked_i (pll_b),
      .cfg_valid_i  (cfg_valid_b),
      .cfg_ready_o  (cfg_ready_b),
      .cfg_ch_i     (cfg_ch_b),
      .cfg_div_i    (cfg_div_b),
      .en_o         (en_b),
      .div_clk_o    (div_clk_b),
      .ch_locked_o  (ch_locked_b),
      .locked_o     (locked_b),
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
      .loss_cnt_o   (loss_cnt_b),
`endif
      .rst_no       (rst_out_b)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Advance n clock edges and settle 1 unit past the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the main instance's config request.
   task automatic applyStimulus(input logic v, input logic [1:0] ch, input logic [7:0] d);
      cfg_valid = v;
      cfg_ch    = ch;
      cfg_div   = d;
   endtask

   // Compare one observed value with its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   // Directed sequence; cycle notes are relative to the pll rise at cycle c.
   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      pll = 1'b0;
      applyStimulus(1'b0, 2'd0, 8'd0);
      pll_b = 1'b0;
      cfg_valid_b = 1'b0;
      cfg_ch_b = 2'd0;
      cfg_div_b = 8'd0;

      step(3);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_rst_no", 32'(rst_out), 32'd0);
      checkOutput("rst_en", 32'(en), 32'd0);
      checkOutput("rst_div_clk", 32'(div_clk), 32'd0);
      checkOutput("rst_ch_locked", 32'(ch_locked), 32'd0);
      checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);

      rst_n = 1'b1;
      step(2);
      checkOutput("wait_lock_locked", 32'(locked), 32'd0);

      // ch1 ratio 5 written before lock goes straight to the div register.
      applyStimulus(1'b1, 2'd1, 8'd5);
      checkOutput("idle_cfg_ready", 32'(cfg_ready), 32'd1);
      step(1);
      applyStimulus(1'b0, 2'd0, 8'd0);
      checkOutput("idle_no_pending", 32'(cfg_ready), 32'd1);

      // Lock sequence: RUN at c+17.
      pll = 1'b1;
      step(16);
      checkOutput("settle_locked", 32'(locked), 32'd0);
      checkOutput("settle_rst_no", 32'(rst_out), 32'd0);
      step(1);
      checkOutput("run_locked", 32'(locked), 32'd1);
      checkOutput("run_rst_no", 32'(rst_out), 32'd1);
      checkOutput("run0_en", 32'(en), 32'h0);
      checkOutput("run0_div_clk", 32'(div_clk), 32'hF);
      checkOutput("run0_ch_locked", 32'(ch_locked), 32'hF);
      step(1);
      checkOutput("run1_en", 32'(en), 32'hD);
      checkOutput("run1_div_clk", 32'(div_clk), 32'h2);
      step(1);
      checkOutput("run2_en", 32'(en), 32'h0);
      checkOutput("run2_div_clk", 32'(div_clk), 32'hD);
      step(1);
      checkOutput("run3_en", 32'(en), 32'hD);
      checkOutput("run3_div_clk", 32'(div_clk), 32'h0);
      step(1);
      checkOutput("run4_en", 32'(en), 32'h2);
      checkOutput("run4_div_clk", 32'(div_clk), 32'hD);
      step(1);
      checkOutput("run5_en", 32'(en), 32'hD);
      checkOutput("run5_div_clk", 32'(div_clk), 32'h2);

      // Runtime change ch1 5 -> 3 mid-period (c+23, ch1 cnt=1).
      step(1);
      applyStimulus(1'b1, 2'd1, 8'd3);
      checkOutput("chg_ready_before", 32'(cfg_ready), 32'd1);
      step(1);
      applyStimulus(1'b0, 2'd0, 8'd0);
      checkOutput("chg_ready_pending", 32'(cfg_ready), 32'd0);
      checkOutput("chg_ch_locked", 32'(ch_locked), 32'hD);
      checkOutput("chg_no_early_en", 32'(en[1]), 32'd0);
      step(2);
      checkOutput("chg_wrap_en", 32'(en), 32'hF);
      checkOutput("chg_wrap_ready", 32'(cfg_ready), 32'd0);
      step(1);
      checkOutput("chg_ready_after", 32'(cfg_ready), 32'd1);
      checkOutput("chg_ch_locked_after", 32'(ch_locked), 32'hF);
      checkOutput("chg_new0_en", 32'(en[1]), 32'd0);
      checkOutput("chg_new0_div_clk", 32'(div_clk[1]), 32'd1);
      step(1);
      checkOutput("chg_new1_en", 32'(en[1]), 32'd0);
      checkOutput("chg_new1_div_clk", 32'(div_clk[1]), 32'd0);
      step(1);
      checkOutput("chg_new2_en", 32'(en[1]), 32'd1);

      // Bypass: ch2 ratio 0 written at c+30.
      step(1);
      applyStimulus(1'b1, 2'd2, 8'd0);
      step(1);
      applyStimulus(1'b0, 2'd0, 8'd0);
      checkOutput("byp_ch_locked", 32'(ch_locked), 32'hB);
      checkOutput("byp_ready", 32'(cfg_ready), 32'd0);
      step(2);
      checkOutput("byp0_en", 32'(en[2]), 32'd1);
      checkOutput("byp0_div_clk", 32'(div_clk[2]), 32'd0);
      checkOutput("byp_ready_after", 32'(cfg_ready), 32'd1);
      step(1);
      checkOutput("byp1_en", 32'(en[2]), 32'd1);
      checkOutput("byp1_div_clk", 32'(div_clk[2]), 32'd0);

      // Odd ratio: ch3 ratio 7 written at c+35, active from c+37.
      step(1);
      applyStimulus(1'b1, 2'd3, 8'd7);
      step(1);
      applyStimulus(1'b0, 2'd0, 8'd0);
      checkOutput("odd_ch_locked", 32'(ch_locked), 32'h7);
      step(1);
      for (int i = 0; i < 7; i++) begin
         checkOutput("odd_div_clk", 32'(div_clk[3]), (i < 3) ? 32'd1 : 32'd0);
         checkOutput("odd_en", 32'(en[3]), (i == 6) ? 32'd1 : 32'd0);
         step(1);
      end
      step(5);
      checkOutput("odd_gap_en", 32'(en[3]), 32'd0);
      step(1);
      checkOutput("odd_second_en", 32'(en[3]), 32'd1);

      // Lock loss with pending ch1 ratio 4 (written at c+51).
      step(1);
      applyStimulus(1'b1, 2'd1, 8'd4);
      step(1);
      applyStimulus(1'b0, 2'd0, 8'd0);
      checkOutput("loss_pending_ch_locked", 32'(ch_locked), 32'hD);
      pll = 1'b0;
      step(1);
      checkOutput("loss_locked", 32'(locked), 32'd0);
      checkOutput("loss_rst_no", 32'(rst_out), 32'd0);
      checkOutput("loss_en", 32'(en), 32'd0);
      checkOutput("loss_div_clk", 32'(div_clk), 32'd0);
      checkOutput("loss_ch_locked", 32'(ch_locked), 32'd0);
      checkOutput("loss_ready", 32'(cfg_ready), 32'd1);
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
      checkOutput("loss_cnt_1", 32'(loss_cnt), 32'd1);
`endif
      pll = 1'b1;
      step(16);
      checkOutput("relock_settle", 32'(locked), 32'd0);
      step(1);
      checkOutput("relock_locked", 32'(locked), 32'd1);
      step(1);
      checkOutput("relock1_en", 32'(en), 32'h5);
      step(2);
      checkOutput("relock3_en", 32'(en), 32'h7);

      // Second lock loss, then a SETTLE abort that must not count.
      pll = 1'b0;
      step(1);
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
      checkOutput("loss_cnt_2", 32'(loss_cnt), 32'd2);
`endif
      pll = 1'b1;
      step(8);
      pll = 1'b0;
      step(1);
      checkOutput("abort_locked", 32'(locked), 32'd0);
      pll = 1'b1;
      step(16);
      checkOutput("abort_settle", 32'(locked), 32'd0);
      step(1);
      checkOutput("abort_relock", 32'(locked), 32'd1);
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
      checkOutput("abort_loss_cnt", 32'(loss_cnt), 32'd2);
`endif

      // Reset mid-RUN with a pending ch0 ratio 6 that must be lost.
      applyStimulus(1'b1, 2'd0, 8'd6);
      step(1);
      applyStimulus(1'b0, 2'd0, 8'd0);
      checkOutput("mid_rst_pending", 32'(cfg_ready), 32'd0);
      rst_n = 1'b0;
      step(1);
      checkOutput("mid_rst_locked", 32'(locked), 32'd0);
      checkOutput("mid_rst_rst_no", 32'(rst_out), 32'd0);
      checkOutput("mid_rst_en", 32'(en), 32'd0);
      checkOutput("mid_rst_div_clk", 32'(div_clk), 32'd0);
      checkOutput("mid_rst_ch_locked", 32'(ch_locked), 32'd0);
      checkOutput("mid_rst_ready", 32'(cfg_ready), 32'd1);
`ifdef CLK_DIV_BANK_LOSS_CNT_EN
      checkOutput("mid_rst_loss_cnt", 32'(loss_cnt), 32'd0);
`endif
      rst_n = 1'b1;
      step(16);
      checkOutput("post_rst_settle", 32'(locked), 32'd0);
      step(1);
      checkOutput("post_rst_locked", 32'(locked), 32'd1);
      step(1);
      checkOutput("post_rst_def_div_en", 32'(en[0]), 32'd1);

      // Out-of-range select on the 3-channel instance (LOCK_WAIT=1, D=3).
      pll_b = 1'b1;
      step(1);
      checkOutput("b_settle", 32'(locked_b), 32'd0);
      step(1);
      checkOutput("b_locked", 32'(locked_b), 32'd1);
      checkOutput("b_en0", 32'(en_b), 32'd0);
      cfg_valid_b = 1'b1;
      cfg_ch_b = 2'd3;
      cfg_div_b = 8'd1;
      checkOutput("b_invalid_ready", 32'(cfg_ready_b), 32'd1);
      step(1);
      cfg_valid_b = 1'b0;
      checkOutput("b_invalid_ready_after", 32'(cfg_ready_b), 32'd1);
      checkOutput("b_invalid_ch_locked", 32'(ch_locked_b), 32'h7);
      checkOutput("b_en1", 32'(en_b), 32'd0);
      step(1);
      checkOutput("b_en2", 32'(en_b), 32'h7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
